// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder: op classes,
// opcode/funct fields, immediate range limits and the field bundle type.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_JALR = 3'd4,
    OP_BGE  = 3'd5,
    OP_JAL  = 3'd6,
    OP_NOP  = 3'd7
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Major opcodes as the core's decoder expects them
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  // BGE shares the JALR major opcode on this core; funct3 tells them apart
  localparam logic [6:0] OPC_BGE   = 7'b1100111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [6:0] F7_ADD  = 7'b0000000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Immediate limits (byte offsets)
  localparam int IMM_I_MIN  = -2048;
  localparam int IMM_I_MAX  = 2047;
  localparam int IMM_SB_MIN = -4096;
  localparam int IMM_SB_MAX = 4094;
  localparam logic [31:0] IMM_JAL_MAX = 32'h001F_FFFE;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: decoded fields -> 32-bit instruction word plus a
// flag saying whether the immediate fits the format of the op class.
module instr_encoder_pack
  import instr_encoder_pkg::*;
(
  input  fields_t     fld,
  output logic [31:0] word,
  output logic        imm_ok
);

  logic signed [31:0] simm;
  logic               i_fits;
  logic               sb_fits;
  logic               jal_fits;

  assign simm = $signed(fld.imm);

  // Range checks for each immediate format
  always_comb begin
    i_fits   = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
    sb_fits  = (simm >= IMM_SB_MIN) && (simm <= IMM_SB_MAX) && !fld.imm[0];
    // JAL immediate is zero-extended, so an unsigned compare also rejects negatives
    jal_fits = (fld.imm <= IMM_JAL_MAX) && !fld.imm[0];
  end

  // Field packing per op class; fields the format has no slot for never reach the word
  always_comb begin
    word   = NOP_WORD;
    imm_ok = 1'b1;
    unique case (fld.op)
      OP_ADD: begin
        word = {F7_ADD, fld.rs2, fld.rs1, F3_ADD, fld.rd, OPC_OP};
      end
      OP_ADDI: begin
        word   = {fld.imm[11:0], fld.rs1, F3_ADD, fld.rd, OPC_OPIMM};
        imm_ok = i_fits;
      end
      OP_LW: begin
        word   = {fld.imm[11:0], fld.rs1, F3_WORD, fld.rd, OPC_LOAD};
        imm_ok = i_fits;
      end
      OP_SW: begin
        word   = {fld.imm[11:5], fld.rs2, fld.rs1, F3_WORD, fld.imm[4:0], OPC_STORE};
        imm_ok = i_fits;
      end
      OP_JALR: begin
        word   = {fld.imm[11:0], fld.rs1, F3_JALR, fld.rd, OPC_JALR};
        imm_ok = i_fits;
      end
      OP_BGE: begin
        word   = {fld.imm[12], fld.imm[10:5], fld.rs2, fld.rs1, F3_BGE,
                  fld.imm[4:1], fld.imm[11], OPC_BGE};
        imm_ok = sb_fits;
      end
      OP_JAL: begin
        word   = {fld.imm[20], fld.imm[10:1], fld.imm[11], fld.imm[19:12], fld.rd, OPC_JAL};
        imm_ok = jal_fits;
      end
      default: begin
        word   = NOP_WORD;
        imm_ok = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: valid/ready field input, one-deep output register
// (EMPTY/HOLD), sequential word addresses, emitted-word count, sticky err.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  fields_t            fld;
  logic [31:0]        pack_word;
  logic               pack_ok;

  state_e             state_q, state_d;
  logic [31:0]        word_q, word_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               err_q, err_d;

  logic               accept;
  logic               load;
  logic               emit;
  logic               full_next_slot;
  logic [ADDR_W+1:0]  slots_used;

  assign fld = '{op: op_e'(in_op), rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  instr_encoder_pack u_pack (
    .fld    (fld),
    .word   (pack_word),
    .imm_ok (pack_ok)
  );

  // Slot accounting: a held word already claims one of the DEPTH slots
  always_comb begin
    slots_used     = {1'b0, count_q} + (ADDR_W+2)'(out_valid);
    full_next_slot = (slots_used == (ADDR_W+2)'(DEPTH));
    full           = (count_q == (ADDR_W+1)'(DEPTH));
  end

  // Output decode of the FSM plus the input handshake
  always_comb begin
    out_valid = (state_q == ST_HOLD);
    in_ready  = !clear && !full_next_slot && (!out_valid || out_ready);
  end

  // Transfer qualifiers; clear suppresses emission of the pending word
  always_comb begin
    accept = in_valid && in_ready;
    load   = accept && pack_ok;
    emit   = out_valid && out_ready && !clear;
  end

  // Next-state: a new word keeps HOLD even when the old one leaves this cycle
  always_comb begin
    state_d = state_q;
    if (clear)     state_d = ST_EMPTY;
    else if (load) state_d = ST_HOLD;
    else if (emit) state_d = ST_EMPTY;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Datapath next values: word, address (saturating), count, sticky err
  always_comb begin
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      word_d  = '0;
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (load) word_d = pack_word;
      if (emit) begin
        count_d = count_q + 1'b1;
        addr_d  = (&addr_q) ? addr_q : addr_q + 1'b1;
      end
      if (accept && !pack_ok) err_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_word = word_q;
  assign out_addr = addr_q;
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (ADDR_W=4, DEPTH=4): the driver pushes
// hand-computed {addr, word} pairs, a monitor pops them on each emit.
module tb_instr_encoder;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_word;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+31:0] sb_q[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_word(out_word),
    .count(count), .full(full), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle, pop on every emit, watch stability under backpressure
  logic              prev_hold = 1'b0;
  logic [31:0]       prev_word;
  logic [ADDR_W-1:0] prev_addr;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (prev_hold && out_valid) begin
          check("hold_word", out_word, prev_word);
          check("hold_addr", 32'(out_addr), 32'(prev_addr));
        end
        if (out_valid && out_ready && !clear) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_emit: got addr %0d word 0x%08h want none", out_addr, out_word);
          end else begin
            logic [ADDR_W+31:0] e;
            e = sb_q.pop_front();
            check("emit_word", out_word, e[31:0]);
            check("emit_addr", 32'(out_addr), 32'(e[ADDR_W+31:32]));
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_word = out_word;
        prev_addr = out_addr;
      end
    end
  end

  // Present a bundle (called at a negedge); push expectation on acceptance
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic good, input logic [31:0] exp_word,
                      input logic [ADDR_W-1:0] exp_addr);
    bit done = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      #1;
      if (in_ready) begin
        if (good) sb_q.push_back({exp_addr, exp_word});
        @(posedge clk);
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready 0 want 1 (op %0d)", op);
    end
  endtask

  // Hold a bundle on the input for n cycles and require it be refused
  task automatic expect_refused(input int n);
    in_op = 3'd0; in_rd = 5'd1; in_rs1 = 5'd1; in_rs2 = 5'd1; in_imm = '0;
    in_valid = 1'b1;
    for (int c = 0; c < n; c++) begin
      #1;
      check("in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((sb_q.size() != 0 || out_valid) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb_q.size());
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic encodings; fields with no slot are driven nonzero
    send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        1, 32'h002081B3, 4'd0);
    send(3'd1, 5'd5, 5'd0, 5'd9, 32'hFFFFFFFF, 1, 32'hFFF00293, 4'd1);
    send(3'd2, 5'd6, 5'd2, 5'd0, 32'd8,        1, 32'h00812303, 4'd2);
    send(3'd3, 5'd9, 5'd2, 5'd7, 32'd4,        1, 32'h00712223, 4'd3);
    drain();
    check("full_count", 32'(count), 32'd4);
    check("full_flag", 32'(full), 32'd1);
    expect_refused(3);
    do_clear();
    check("clr_count", 32'(count), 32'd0);
    check("clr_full", 32'(full), 32'd0);

    // Branch, then bad immediates: accepted but produce nothing
    send(3'd5, 5'd31, 5'd1, 5'd2, 32'hFFFFFFFC, 1, 32'hFE20DEE7, 4'd0);
    drain();
    send(3'd5, 5'd0, 5'd1, 5'd2, 32'd3,    0, 32'd0, 4'd0);
    send(3'd1, 5'd1, 5'd1, 5'd0, 32'd4096, 0, 32'd0, 4'd0);
    drain();
    check("bad_err", 32'(err), 32'd1);
    check("bad_count", 32'(count), 32'd1);
    send(3'd6, 5'd1, 5'd7, 5'd7, 32'h00000800, 1, 32'h001000EF, 4'd1);
    send(3'd7, 5'd9, 5'd9, 5'd9, 32'h12345678, 1, 32'h00000013, 4'd2);
    send(3'd4, 5'd1, 5'd5, 5'd3, 32'd16,       1, 32'h010280E7, 4'd3);
    drain();
    check("mix_count", 32'(count), 32'd4);
    check("mix_err_sticky", 32'(err), 32'd1);
    do_clear();
    check("clr_err", 32'(err), 32'd0);

    // Backpressure: held word stays put, input refused while stalled
    out_ready = 1'b0;
    send(3'd1, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h00500093, 4'd0);
    expect_refused(5);
    out_ready = 1'b1;
    send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3, 4'd1);
    drain();
    check("bp_count", 32'(count), 32'd2);
    do_clear();

    // Stream six: only four fit, then clear restarts at address 0
    send(3'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1, 32'h001080B3, 4'd0);
    send(3'd0, 5'd2, 5'd1, 5'd1, 32'd0, 1, 32'h00108133, 4'd1);
    send(3'd0, 5'd3, 5'd1, 5'd1, 32'd0, 1, 32'h001081B3, 4'd2);
    send(3'd0, 5'd4, 5'd1, 5'd1, 32'd0, 1, 32'h00108233, 4'd3);
    expect_refused(3);
    expect_refused(3);
    drain();
    check("stream_full", 32'(full), 32'd1);
    check("stream_count", 32'(count), 32'd4);
    do_clear();
    send(3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 1, 32'h00000013, 4'd0);
    drain();
    check("restart_count", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
